// File: rtl/fb_pkg.sv
// Shared framebuffer types, default geometry and the row/column address helper.
// The FB_CLEAR state exists only when FB_LINE_WRITER_CLEAR_EN is defined.
package fb_pkg;

   localparam int FB_WIDTH  = 640;
   localparam int FB_HEIGHT = 480;
   localparam int FB_PIX_W  = 3;

   typedef enum logic [1:0] {
      FB_IDLE   = 2'd0,
      FB_WRITE  = 2'd1,
      FB_FINISH = 2'd2
`ifdef FB_LINE_WRITER_CLEAR_EN
      ,
      FB_CLEAR  = 2'd3
`endif
   } fb_wr_state_t;

   // Linear RAM address of a pixel; also used by the VGA scan address generator.
   function automatic int unsigned fb_addr(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned width = FB_WIDTH);
      return row * width + col;
   endfunction

endpackage

// File: rtl/fb_line_writer_if.sv
// Line handshake plus display-RAM write port of the framebuffer line writer.
// master = UART/arbiter side, slave = fb_line_writer.
interface fb_line_writer_if
   import fb_pkg::*;
#(
   parameter int PIX_W  = FB_PIX_W,
   parameter int WIDTH  = FB_WIDTH,
   parameter int ROW_W  = 9,
   parameter int ADDR_W = 19
);
   logic                     line_valid;
   logic                     line_ready;
   logic [ROW_W-1:0]         line_row;
   logic [PIX_W*WIDTH-1:0]   line_data;
   logic                     ram_grant;
   logic                     ram_we;
   logic [ADDR_W-1:0]        ram_addr;
   logic [PIX_W-1:0]         ram_data;
   logic                     done;
   logic                     row_err;
   logic                     busy;
   logic                     clr_req;
   logic [PIX_W-1:0]         clr_pix;

   modport master (
      output line_valid, line_row, line_data, ram_grant, clr_req, clr_pix,
      input  line_ready, ram_we, ram_addr, ram_data, done, row_err, busy
   );

   modport slave (
      input  line_valid, line_row, line_data, ram_grant, clr_req, clr_pix,
      output line_ready, ram_we, ram_addr, ram_data, done, row_err, busy
   );
endinterface

// File: rtl/fb_line_shifter.sv
// Shadow register holding one pixel line; loads a full line and shifts out
// one pixel (PIX_W bits) at a time, pixel 0 always in the low bits.
module fb_line_shifter
   import fb_pkg::*;
#(
   parameter int PIX_W = FB_PIX_W,
   parameter int WIDTH = FB_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load,
   input  logic                   shift,
   input  logic [PIX_W*WIDTH-1:0] line_in,
   output logic [PIX_W-1:0]       pix0
);
   logic [PIX_W*WIDTH-1:0] shadow_q, shadow_d;

   always_comb begin
      shadow_d = shadow_q;
      if (load) begin
         shadow_d = line_in;
      end else if (shift) begin
         shadow_d = shadow_q >> PIX_W;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end

   assign pix0 = shadow_q[PIX_W-1:0];

endmodule

// File: rtl/fb_line_writer.sv
// Accepts one pixel line via valid/ready and writes it into the display RAM on
// arbiter-granted cycles. Frame clear is compiled in with FB_LINE_WRITER_CLEAR_EN.
module fb_line_writer
   import fb_pkg::*;
#(
   parameter int PIX_W  = FB_PIX_W,
   parameter int WIDTH  = FB_WIDTH,
   parameter int HEIGHT = FB_HEIGHT,
   parameter int ROW_W  = 9,
   parameter int COL_W  = 10,
   parameter int ADDR_W = 19
) (
   input logic             clk,
   input logic             rst_n,
   fb_line_writer_if.slave bus
);
   localparam int unsigned      HEIGHT_U = HEIGHT;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

   fb_wr_state_t      state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic              row_err_q, row_err_d;

   logic [ROW_W-1:0]  row_in;
   logic              line_ready;
   logic              accept;
   logic              load;
   logic              shift;
   logic [PIX_W-1:0]  pix0;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [PIX_W-1:0]  ram_data;

   assign row_in = bus.line_row;

`ifdef FB_LINE_WRITER_CLEAR_EN
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
   // A clear request wins over a simultaneous line, so hold off the handshake.
   assign line_ready = (state_q == FB_IDLE) && !bus.clr_req;
`else
   logic unused_clr;
   assign unused_clr = ^{bus.clr_req, bus.clr_pix};
   assign line_ready = (state_q == FB_IDLE);
`endif

   assign accept = bus.line_valid && line_ready;

   fb_line_shifter #(
      .PIX_W (PIX_W),
      .WIDTH (WIDTH)
   ) u_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .shift   (shift),
      .line_in (bus.line_data),
      .pix0    (pix0)
   );

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      col_d     = col_q;
      row_err_d = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      unique case (state_q)
         FB_IDLE: begin
`ifdef FB_LINE_WRITER_CLEAR_EN
            if (bus.clr_req) begin
               base_d  = '0;
               state_d = FB_CLEAR;
            end else
`endif
            if (accept) begin
               if (32'(row_in) < HEIGHT_U) begin
                  load    = 1'b1;
                  base_d  = ADDR_W'(fb_addr(32'(row_in), 0, WIDTH));
                  col_d   = '0;
                  state_d = FB_WRITE;
               end else begin
                  row_err_d = 1'b1;
               end
            end
         end
         FB_WRITE: begin
            if (bus.ram_grant) begin
               col_d = col_q + COL_W'(1);
               shift = 1'b1;
               if (col_q == LAST_COL) begin
                  state_d = FB_FINISH;
               end
            end
         end
`ifdef FB_LINE_WRITER_CLEAR_EN
         // base doubles as the running clear address.
         FB_CLEAR: begin
            if (bus.ram_grant) begin
               base_d = base_q + ADDR_W'(1);
               if (base_q == LAST_ADDR) begin
                  state_d = FB_FINISH;
               end
            end
         end
`endif
         FB_FINISH: begin
            state_d = FB_IDLE;
         end
         default: begin
            state_d = FB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FB_IDLE;
         base_q    <= '0;
         col_q     <= '0;
         row_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         col_q     <= col_d;
         row_err_q <= row_err_d;
      end
   end

   // RAM port is driven straight from registers; zero outside write states.
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_data = '0;
      case (state_q)
         FB_WRITE: begin
            ram_we   = bus.ram_grant;
            ram_addr = base_q + ADDR_W'(col_q);
            ram_data = pix0;
         end
`ifdef FB_LINE_WRITER_CLEAR_EN
         FB_CLEAR: begin
            ram_we   = bus.ram_grant;
            ram_addr = base_q;
            ram_data = bus.clr_pix;
         end
`endif
         default: begin
            ram_we   = 1'b0;
         end
      endcase
   end

   assign bus.line_ready = line_ready;
   assign bus.ram_we     = ram_we;
   assign bus.ram_addr   = ram_addr;
   assign bus.ram_data   = ram_data;
   assign bus.done       = (state_q == FB_FINISH);
   assign bus.row_err    = row_err_q;
   assign bus.busy       = (state_q != FB_IDLE);

endmodule

// File: tb/tb_fb_line_writer.sv
// Scoreboard bench for fb_line_writer (WIDTH=8, HEIGHT=4, PIX_W=3).
// Define FB_LINE_WRITER_CLEAR_EN to also exercise the frame clear.
module tb_fb_line_writer;
   import fb_pkg::*;

   localparam int PIX_W  = 3;
   localparam int WIDTH  = 8;
   localparam int HEIGHT = 4;
   localparam int ROW_W  = 3;
   localparam int COL_W  = 4;
   localparam int ADDR_W = 5;
   localparam int LW     = PIX_W * WIDTH;

   typedef logic [ADDR_W+PIX_W-1:0] wr_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fb_line_writer_if #(.PIX_W(PIX_W), .WIDTH(WIDTH), .ROW_W(ROW_W), .ADDR_W(ADDR_W)) bus ();

   fb_line_writer #(
      .PIX_W (PIX_W), .WIDTH (WIDTH), .HEIGHT (HEIGHT),
      .ROW_W (ROW_W), .COL_W (COL_W), .ADDR_W (ADDR_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   wr_t exp_q[$];
   int  n_vec = 0;
   int  n_err = 0;
   int  wr_cnt = 0;
   int  done_cnt = 0;
   time last_wr_t = 0;
   time done_t = 0;

   // Scoreboard: every observed RAM write is popped against the expected queue.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.ram_we === 1'b1) begin
         wr_t e;
         wr_cnt++;
         last_wr_t = $time;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write got addr=%0d data=%0d, required no write",
                     bus.ram_addr, bus.ram_data);
         end else begin
            e = exp_q.pop_front();
            if ({bus.ram_addr, bus.ram_data} !== e) begin
               n_err++;
               $display("FAIL ram_write got addr=%0d data=%0d, required addr=%0d data=%0d",
                        bus.ram_addr, bus.ram_data, e[ADDR_W+PIX_W-1:PIX_W], e[PIX_W-1:0]);
            end
         end
      end
      if (bus.done === 1'b1) begin
         done_cnt++;
         done_t = $time;
      end
   end

   function automatic logic [LW-1:0] mk_line(input int seed);
      logic [LW-1:0] d;
      d = '0;
      for (int i = 0; i < WIDTH; i++) d[i*PIX_W +: PIX_W] = PIX_W'(i + 1 + seed);
      return d;
   endfunction

   // Present one line for a single cycle; expected writes are queued for valid rows.
   task automatic offer_line(input int row, input logic [LW-1:0] data);
      bus.line_valid = 1'b1;
      bus.line_row   = row[ROW_W-1:0];
      bus.line_data  = data;
      if (row < HEIGHT)
         for (int i = 0; i < WIDTH; i++)
            exp_q.push_back({ADDR_W'(row * WIDTH + i), data[i*PIX_W +: PIX_W]});
      @(posedge clk); #1;
      bus.line_valid = 1'b0;
      bus.line_row   = '0;
      bus.line_data  = '0;
   endtask

   task automatic wait_done(input int budget, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.line_valid = 1'b0; bus.line_row = '0; bus.line_data = '0;
      bus.ram_grant = 1'b1; bus.clr_req = 1'b0; bus.clr_pix = '0;
      #1;
      n_vec++;
      if ({bus.line_ready, bus.ram_we, bus.done, bus.row_err, bus.busy} !== 5'b10000) begin
         n_err++;
         $display("FAIL reset_flags got ready/we/done/err/busy=%b, required 10000",
                  {bus.line_ready, bus.ram_we, bus.done, bus.row_err, bus.busy});
      end
      n_vec++;
      if (bus.ram_addr !== '0 || bus.ram_data !== '0) begin
         n_err++;
         $display("FAIL reset_bus got addr=%0d data=%0d, required 0/0", bus.ram_addr, bus.ram_data);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_basic();
      @(posedge clk); #1;
      bus.ram_grant = 1'b1;
      offer_line(2, mk_line(0));
      for (int k = 1; k <= WIDTH; k++) begin
         @(negedge clk);
         n_vec++;
         if (bus.ram_we !== 1'b1 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_write_cycle%0d got we=%b busy=%b, required 1/1", k, bus.ram_we, bus.busy);
         end
      end
      @(negedge clk);
      n_vec++;
      if (bus.done !== 1'b1 || bus.ram_we !== 1'b0) begin
         n_err++;
         $display("FAIL basic_done got done=%b we=%b, required 1/0", bus.done, bus.ram_we);
      end
      @(negedge clk);
      n_vec++;
      if (bus.line_ready !== 1'b1 || bus.done !== 1'b0) begin
         n_err++;
         $display("FAIL basic_ready got ready=%b done=%b, required 1/0", bus.line_ready, bus.done);
      end
   endtask

   task automatic test_grant_toggle();
      int w0;
      bit seen;
      @(posedge clk); #1;
      w0 = wr_cnt;
      bus.ram_grant = 1'b1;
      offer_line(2, mk_line(0));
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
         bus.ram_grant = ~bus.ram_grant;
      end
      @(posedge clk); #1;
      bus.ram_grant = 1'b1;
      n_vec++;
      if (!seen || wr_cnt - w0 != WIDTH || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL toggle_count got done=%0d writes=%0d left=%0d, required 1/%0d/0",
                  seen, wr_cnt - w0, exp_q.size(), WIDTH);
      end
      n_vec++;
      if (done_t - last_wr_t != 10) begin
         n_err++;
         $display("FAIL toggle_done_gap got %0t, required 10", done_t - last_wr_t);
      end
   endtask

   task automatic test_bad_row();
      int w0;
      @(posedge clk); #1;
      w0 = wr_cnt;
      offer_line(4, mk_line(3));
      @(negedge clk);
      n_vec++;
      if (bus.row_err !== 1'b1 || bus.line_ready !== 1'b1 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL bad_row_pulse got err=%b ready=%b busy=%b, required 1/1/0",
                  bus.row_err, bus.line_ready, bus.busy);
      end
      @(negedge clk);
      n_vec++;
      if (bus.row_err !== 1'b0 || wr_cnt != w0) begin
         n_err++;
         $display("FAIL bad_row_after got err=%b writes=%0d, required 0/0", bus.row_err, wr_cnt - w0);
      end
   endtask

   task automatic test_ignore_valid();
      bit seen;
      int w0;
      @(posedge clk); #1;
      w0 = wr_cnt;
      offer_line(1, mk_line(2));
      bus.line_valid = 1'b1;
      bus.line_row   = 3'd3;
      bus.line_data  = mk_line(5);
      repeat (4) begin
         @(negedge clk);
         n_vec++;
         if (bus.line_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_ready got %b, required 0", bus.line_ready);
         end
      end
      @(posedge clk); #1;
      bus.line_valid = 1'b0;
      wait_done(20, seen);
      n_vec++;
      if (!seen || wr_cnt - w0 != WIDTH || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL ignore_line got done=%0d writes=%0d left=%0d, required 1/%0d/0",
                  seen, wr_cnt - w0, exp_q.size(), WIDTH);
      end
   endtask

   task automatic test_reset_mid();
      int d0;
      bit seen;
      @(posedge clk); #1;
      bus.ram_grant = 1'b1;
      offer_line(0, mk_line(4));
      repeat (3) @(negedge clk);
      d0 = done_cnt;
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({bus.line_ready, bus.ram_we, bus.busy, bus.done} !== 4'b1000 || bus.ram_addr !== '0) begin
         n_err++;
         $display("FAIL midreset_async got ready/we/busy/done=%b addr=%0d, required 1000/0",
                  {bus.line_ready, bus.ram_we, bus.busy, bus.done}, bus.ram_addr);
      end
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if (done_cnt != d0) begin
         n_err++;
         $display("FAIL midreset_done got %0d pulses, required 0", done_cnt - d0);
      end
      @(posedge clk); #1;
      offer_line(3, mk_line(6));
      wait_done(20, seen);
      n_vec++;
      if (!seen || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL midreset_next got done=%0d left=%0d, required 1/0", seen, exp_q.size());
      end
   endtask

`ifdef FB_LINE_WRITER_CLEAR_EN
   task automatic test_clear();
      bit seen;
      int d0;
      @(posedge clk); #1;
      d0 = done_cnt;
      for (int a = 0; a < WIDTH * HEIGHT; a++) exp_q.push_back({ADDR_W'(a), 3'd5});
      bus.clr_req = 1'b1; bus.clr_pix = 3'd5;
      bus.line_valid = 1'b1; bus.line_row = 3'd2; bus.line_data = mk_line(1);
      @(negedge clk);
      n_vec++;
      if (bus.line_ready !== 1'b0) begin
         n_err++;
         $display("FAIL clear_priority got ready=%b, required 0", bus.line_ready);
      end
      @(posedge clk); #1;
      bus.clr_req = 1'b0;
      wait_done(60, seen);
      n_vec++;
      if (!seen || exp_q.size() != 0 || done_cnt - d0 != 1) begin
         n_err++;
         $display("FAIL clear_run got done=%0d pulses=%0d left=%0d, required 1/1/0",
                  seen, done_cnt - d0, exp_q.size());
      end
      for (int i = 0; i < WIDTH; i++)
         exp_q.push_back({ADDR_W'(2 * WIDTH + i), bus.line_data[i*PIX_W +: PIX_W]});
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.line_valid = 1'b0;
      wait_done(20, seen);
      n_vec++;
      if (!seen || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL clear_pending got done=%0d left=%0d, required 1/0", seen, exp_q.size());
      end
   endtask
`else
   task automatic test_clr_ignored();
      bit seen;
      int w0;
      @(posedge clk); #1;
      w0 = wr_cnt;
      bus.clr_req = 1'b1; bus.clr_pix = 3'd5;
      offer_line(1, mk_line(3));
      wait_done(20, seen);
      bus.clr_req = 1'b0;
      n_vec++;
      if (!seen || wr_cnt - w0 != WIDTH || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL clr_ignored got done=%0d writes=%0d left=%0d, required 1/%0d/0",
                  seen, wr_cnt - w0, exp_q.size(), WIDTH);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_grant_toggle();
      test_bad_row();
      test_ignore_valid();
      test_reset_mid();
`ifdef FB_LINE_WRITER_CLEAR_EN
      test_clear();
`else
      test_clr_ignored();
`endif
      repeat (3) @(posedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL final_queue got %0d pending writes, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fb_line_writer.md
Name: fb_line_writer

Overview:
- Parametrised successor to the UART-to-framebuffer write path.
- Accepts one complete received pixel line: row index plus packed pixel vector, via a valid/ready handshake.
- Streams the line pixel by pixel into the display RAM port, only on cycles where the VGA-side arbiter grants the port.
- Reports completion or a bad row. Sits between UART_Controller and the single-port display RAM mux.

Parameters:
- PIX_W, 3, bits per pixel (palette index width).
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- ROW_W, 9, width of the row index; must be >= clog2(HEIGHT).
- COL_W, 10, width of the column counter; must be >= clog2(WIDTH+1).
- ADDR_W, 19, RAM address width; must be >= clog2(WIDTH*HEIGHT).

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- line_valid  in  1  line offered.
- line_ready  out  1  block can accept a line.
- line_row  in  ROW_W  target row.
- line_data  in  PIX_W*WIDTH  packed pixels; pixel 0 in bits [PIX_W-1:0].
- ram_grant  in  1  arbiter permits a write this cycle.
- ram_we  out  1  write strobe.
- ram_addr  out  ADDR_W  write address.
- ram_data  out  PIX_W  write pixel.
- done  out  1  one-cycle pulse when a line is fully written.
- row_err  out  1  one-cycle pulse when a line is rejected.
- busy  out  1  high whenever the FSM is not in IDLE.
- clr_req  in  1  frame-clear request (optional feature).
- clr_pix  in  PIX_W  clear colour (optional feature).

Behaviour:
- Reset values: state IDLE; line_ready 1; ram_we 0; ram_addr 0; ram_data 0; done 0; row_err 0; busy 0. Shadow line register and counters are cleared.
- FSM states: IDLE, WRITE, FINISH, plus CLEAR when the optional feature is compiled in.
- line_ready = (state==IDLE). A handshake occurs when line_valid && line_ready.
- On handshake with line_row < HEIGHT:
  - latch line_data into the shadow register;
  - base <= line_row*WIDTH, truncated to ADDR_W;
  - col <= 0; go to WRITE.
- On handshake with line_row >= HEIGHT: row_err pulses next cycle, no RAM write occurs, state stays IDLE.
- In WRITE:
  - ram_addr = base+col; ram_data = shadow[PIX_W-1:0]; ram_we = ram_grant. All are combinational from registers.
  - When ram_grant=1: col increments and shadow shifts right by PIX_W.
  - When ram_grant=0: hold everything, no write.
  - On the granted write with col==WIDTH-1, go to FINISH.
- FINISH lasts one cycle: done=1, then return to IDLE, where line_ready is high again.
- Latency with ram_grant held high: handshake at cycle 0, writes in cycles 1..WIDTH, done in cycle WIDTH+1, next accept possible in cycle WIDTH+2.
- line_valid is ignored while not ready. Inputs need not be held after the handshake.
- Reset asserted mid-line aborts the line immediately. Already-written pixels remain in RAM, and no done pulse is issued.
- ram_addr and ram_data are 0 whenever ram_we cannot be asserted.

Optional Feature:
- Macro: FB_LINE_WRITER_CLEAR_EN.
- With the macro defined:
  - clr_req sampled in IDLE has priority over a simultaneous line_valid; line_ready is 0 on that cycle.
  - The FSM enters CLEAR and writes clr_pix to addresses 0..WIDTH*HEIGHT-1, one per granted cycle.
  - On the last address it goes to FINISH; done pulses once.
- Without the macro: the clr_req and clr_pix ports still exist but are ignored, and the CLEAR state is not generated.

Decomposition:
- Package fb_pkg holds:
  - the state enum fb_wr_state_t;
  - the default constants FB_WIDTH, FB_HEIGHT, FB_PIX_W;
  - function fb_addr(row,col), returning row*WIDTH+col, shared with VGA_Controller address generation.
- One natural sub-module: fb_line_shifter, containing the shadow register with load/shift-by-PIX_W and its pixel-0 output.
- The FSM and counters stay in fb_line_writer.

Test Plan (WIDTH=8, HEIGHT=4, PIX_W=3 unless stated):
- Line row=2, data pixels 0..7 = 1,2,3,4,5,6,7,0, grant held high -> writes at addresses 16..23 with data 1..7,0 in cycles 1..8; done in cycle 9; line_ready high in cycle 10.
- Same line with grant toggling 1,0,1,0... -> exactly 8 writes, no address skipped or repeated; done follows the 8th write.
- Line row=4 (>=HEIGHT) -> row_err pulse for one cycle; zero ram_we; line_ready stays 1.
- line_valid asserted during WRITE with a different row -> ignored; the first line completes unchanged.
- rst_n low after 3 writes -> outputs return to reset values asynchronously; no done pulse; a new line is then accepted normally.
- With FB_LINE_WRITER_CLEAR_EN, clr_req and line_valid together, clr_pix=5 -> 32 writes of 5 to addresses 0..31, one done pulse, then the pending line is accepted.
